// File: rtl/fdiv_pkg.sv
// Shared definitions for the programmable clock-enable divider: mode encodings
// and the configuration record used for both staged and active settings.
`ifndef FDIV_CFG_T
`define FDIV_CFG_T(w) struct packed { logic [(w)-1:0] div; logic [(w)-1:0] high; logic mode; }
`endif
`ifndef FDIV_W
`define FDIV_W 8
`endif

package fdiv_pkg;
    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_TGL = 1'b1;

    // Default-width record; modules build their own with `FDIV_CFG_T(W).
    typedef `FDIV_CFG_T(`FDIV_W) fdiv_cfg_t;
endpackage

// File: rtl/fdiv_if.sv
// Control/status bundle of fdiv_prog: enable, restart, settings load strobe
// and the divided outputs.
interface fdiv_if #(
    parameter int W = 8
) ();
    logic         en;
    logic         restart;
    logic         load;
    logic [W-1:0] div_in;
    logic [W-1:0] high_in;
    logic         mode_in;
    logic         load_pend;
    logic         fout;
    logic         tick;

    modport master (
        output en, restart, load, div_in, high_in, mode_in,
        input  load_pend, fout, tick
    );

    modport slave (
        input  en, restart, load, div_in, high_in, mode_in,
        output load_pend, fout, tick
    );
endinterface

// File: rtl/fdiv_cfg_shadow.sv
// Shadow/active settings store: captures loads, flags them pending and hands
// them to the active set at a period boundary or on restart.
module fdiv_cfg_shadow
    import fdiv_pkg::*;
#(
    parameter int W        = 8,
    parameter int DIV_RST  = 2,
    parameter int HIGH_RST = 1,
    parameter int MODE_RST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic         term,
    input  logic         load,
    input  logic [W-1:0] div_in,
    input  logic [W-1:0] high_in,
    input  logic         mode_in,
    output logic         pend,
    output logic [W-1:0] div_q,
    output logic [W-1:0] high_q,
    output logic         mode_q
);
    typedef `FDIV_CFG_T(W) cfg_t;

    cfg_t shadow_reg;
    cfg_t active_reg;
    cfg_t load_cfg;
    logic pend_reg;

    assign load_cfg = '{div: div_in, high: high_in, mode: mode_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            active_reg <= '{div: W'(DIV_RST), high: W'(HIGH_RST), mode: 1'(MODE_RST)};
            shadow_reg <= '0;
            pend_reg   <= 1'b0;
        end else if (restart) begin
            // A load coinciding with restart bypasses the shadow entirely.
            if (load)
                active_reg <= load_cfg;
            else if (pend_reg)
                active_reg <= shadow_reg;
            pend_reg <= 1'b0;
        end else begin
            if (term && pend_reg) begin
                active_reg <= shadow_reg;
                pend_reg   <= 1'b0;
            end
            // Listed last so a load on the boundary cycle stays pending.
            if (load) begin
                shadow_reg <= load_cfg;
                pend_reg   <= 1'b1;
            end
        end
    end

    assign pend   = pend_reg;
    assign div_q  = active_reg.div;
    assign high_q = active_reg.high;
    assign mode_q = active_reg.mode;
endmodule

// File: rtl/fdiv_prog.sv
// Runtime-programmable clock-enable divider with toggle and PWM output modes
// and a one-cycle end-of-period tick.
module fdiv_prog
    import fdiv_pkg::*;
#(
    parameter int W        = 8,
    parameter int DIV_RST  = 2,
    parameter int HIGH_RST = 1,
    parameter int MODE_RST = 1
) (
    input logic  fin,
    input logic  rst,
    fdiv_if.slave bus
);
    logic [W-1:0] cnt_reg;
    logic [W-1:0] div_q;
    logic [W-1:0] high_q;
    logic         mode_q;
    logic         pend;
    logic         fout_reg;
    logic         tick_reg;
    logic         term;

    assign term = bus.en && (cnt_reg == div_q);

    fdiv_cfg_shadow #(
        .W        (W),
        .DIV_RST  (DIV_RST),
        .HIGH_RST (HIGH_RST),
        .MODE_RST (MODE_RST)
    ) u_cfg (
        .clk     (fin),
        .rst     (rst),
        .restart (bus.restart),
        .term    (term),
        .load    (bus.load),
        .div_in  (bus.div_in),
        .high_in (bus.high_in),
        .mode_in (bus.mode_in),
        .pend    (pend),
        .div_q   (div_q),
        .high_q  (high_q),
        .mode_q  (mode_q)
    );

    always_ff @(posedge fin) begin
        if (rst || bus.restart) begin
            cnt_reg  <= '0;
            fout_reg <= 1'b0;
            tick_reg <= 1'b0;
        end else if (bus.en) begin
            cnt_reg  <= term ? '0 : cnt_reg + 1'b1;
            tick_reg <= term;
            if (mode_q == MODE_TGL)
                fout_reg <= fout_reg ^ term;
            else
                fout_reg <= (cnt_reg < high_q);
        end else begin
            tick_reg <= 1'b0;
        end
    end

    assign bus.fout      = fout_reg;
    assign bus.tick      = tick_reg;
    assign bus.load_pend = pend;
endmodule

// File: tb/tb_fdiv_prog.sv
// Directed bench for fdiv_prog: default divide, staged loads, boundary-timed
// loads, PWM extremes, enable freeze, restart and reset.
module tb_fdiv_prog;
    localparam int W = 8;

    logic fin = 1'b0;
    logic rst;
    int   vectors    = 0;
    int   miscompares = 0;

    fdiv_if #(.W(W)) bus ();

    fdiv_prog #(
        .W        (W),
        .DIV_RST  (2),
        .HIGH_RST (1),
        .MODE_RST (1)
    ) dut (
        .fin (fin),
        .rst (rst),
        .bus (bus)
    );

    always #5 fin = ~fin;

    task automatic step();
        @(posedge fin);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int idx, input logic t, input logic f, input logic p);
        chk({tag, ".tick"}, idx, bus.tick, t);
        chk({tag, ".fout"}, idx, bus.fout, f);
        chk({tag, ".pend"}, idx, bus.load_pend, p);
    endtask

    task automatic do_load(input logic [W-1:0] d, input logic [W-1:0] h, input logic m);
        bus.load    = 1'b1;
        bus.div_in  = d;
        bus.high_in = h;
        bus.mode_in = m;
    endtask

    initial begin
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.restart = 1'b0;
        bus.load    = 1'b0;
        bus.div_in  = '0;
        bus.high_in = '0;
        bus.mode_in = 1'b0;
        step();
        step();
        chk3("reset", 0, 1'b0, 1'b0, 1'b0);

        // Defaults: period 3, toggle mode -> fout period 6
        rst    = 1'b0;
        bus.en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            chk3("dflt", k, (k % 3) == 0, ((k / 3) % 2) == 1, 1'b0);
        end

        // Load D=4 H=2 PWM with cnt=1
        step();
        chk3("pre_load", 0, 1'b0, 1'b0, 1'b0);
        do_load(8'd4, 8'd2, 1'b0);
        step();
        bus.load = 1'b0;
        chk3("load_cap", 0, 1'b0, 1'b0, 1'b1);
        step();
        chk3("load_apply", 0, 1'b1, 1'b1, 1'b0);
        for (int j = 1; j <= 15; j++) begin
            step();
            chk3("pwm5", j, (j % 5) == 0, ((j % 5) == 1) || ((j % 5) == 2), 1'b0);
        end

        // Load exactly on the terminal cycle: one more old period follows
        for (int j = 1; j <= 4; j++) begin
            step();
            chk3("pre_term", j, 1'b0, j <= 2, 1'b0);
        end
        do_load(8'd3, 8'd0, 1'b0);
        step();
        bus.load = 1'b0;
        chk3("term_load", 0, 1'b1, 1'b0, 1'b1);
        for (int j = 1; j <= 5; j++) begin
            step();
            chk3("old_period", j, j == 5, j <= 2, j != 5);
        end

        // H=0 -> constant low, tick every 4
        for (int k = 1; k <= 8; k++) begin
            step();
            chk3("h0", k, (k % 4) == 0, 1'b0, 1'b0);
        end

        // H=7 >= P -> constant high after the next boundary
        do_load(8'd3, 8'd7, 1'b0);
        step();
        bus.load = 1'b0;
        chk3("h7_cap", 0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk3("h7_wait", k, k == 3, 1'b0, k != 3);
        end
        for (int m = 1; m <= 10; m++) begin
            step();
            chk3("h7", m, (m % 4) == 0, 1'b1, 1'b0);
        end

        // Freeze at cnt=2 for 5 cycles
        bus.en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk3("frozen", k, 1'b0, 1'b1, 1'b0);
        end
        bus.en = 1'b1;
        step();
        chk3("resume", 1, 1'b0, 1'b1, 1'b0);
        step();
        chk3("resume", 2, 1'b1, 1'b1, 1'b0);

        // Pending D=1 toggle, then restart mid-period
        do_load(8'd1, 8'd1, 1'b1);
        step();
        bus.load = 1'b0;
        chk3("rs_cap", 0, 1'b0, 1'b1, 1'b1);
        step();
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        chk3("restart", 0, 1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 6; n++) begin
            step();
            chk3("p2", n, (n % 2) == 0, ((n / 2) % 2) == 1, 1'b0);
        end

        // Restart with simultaneous load D=0: direct apply, tick every cycle
        do_load(8'd0, 8'd0, 1'b1);
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        bus.load    = 1'b0;
        chk3("rs_load", 0, 1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            step();
            chk3("d0", n, 1'b1, (n % 2) == 1, 1'b0);
        end

        // Pending load discarded by reset
        do_load(8'd5, 8'd5, 1'b0);
        step();
        bus.load = 1'b0;
        chk3("rst_cap", 0, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk3("mid_rst", 0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk3("post_rst", k, (k % 3) == 0, ((k / 3) % 2) == 1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
